game_progress_ctrl: RTL
=======================

GAME_PROGRESS_CTRL -- requirements
Module: game_progress_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 5: rounds per game, legal range 2..15.
REQ-002 Parameter SCORE_W, default 16: width of total_score and high_score.
REQ-003 Parameter K_W, default 4: width of difficulty_k.
REQ-004 Parameter K_INIT, default 4: difficulty_k at game start.
REQ-005 Parameter BASE_PTS, default 10: points for clearing round 1.
REQ-006 Parameter STEP_PTS, default 5: extra points per later round.
REQ-007 Parameter MAX_LIVES, default 3: lives at game start, legal range 1..7.
REQ-008 Port clk, input, 1: single clock; all logic updates on its rising edge.
REQ-009 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-010 Port round_clear, input, 1: level, round answered correctly.
REQ-011 Port game_fail, input, 1: level, round answered wrongly.
REQ-012 Port game_reset, input, 1: level, start a new game while keeping high_score.
REQ-013 Port current_round, output, ROUND_W = $clog2(NUM_ROUNDS+1): 1-based round number.
REQ-014 Port difficulty_k, output, K_W: difficulty level.
REQ-015 Port total_score, output, SCORE_W: score for the current game.
REQ-016 Port high_score, output, SCORE_W: best final score since rst_n.
REQ-017 Port lives, output, 3: remaining lives.
REQ-018 Port game_state, output, 2: PLAY=0, OVER=1, WON=2.
REQ-019 Port score_evt, output, 1: one-cycle pulse on every total_score change.

Function
REQ-020 round_clear and game_fail each SHALL be rising-edge detected against a registered copy of the input; a level held high SHALL count once.
REQ-021 An accepted event SHALL update the outputs at the same clk edge at which the input is first sampled high.
REQ-022 Clear in PLAY, with r = current_round:
- total_score SHALL increase by BASE_PTS + (r-1)*STEP_PTS, saturating at 2^SCORE_W-1.
- score_evt SHALL pulse.
REQ-023 Clear in PLAY with r < NUM_ROUNDS:
- current_round SHALL increment.
- difficulty_k SHALL increment, saturating at 2^K_W-1.
REQ-024 Clear in PLAY with r = NUM_ROUNDS: current_round SHALL hold and game_state SHALL go to WON.
REQ-025 Fail in PLAY: lives SHALL decrement and current_round and difficulty_k SHALL hold (retry); total_score SHALL not change.
REQ-026 Fail in PLAY with lives = 1: lives SHALL become 0 and game_state SHALL go to OVER.
REQ-027 On entry to OVER or WON, high_score SHALL be updated to the final total_score if that score is larger, at the same edge.
REQ-028 In OVER and WON, round_clear and game_fail SHALL be ignored and all outputs SHALL hold.
REQ-029 If both edges are detected in the same cycle, the clear SHALL take effect and the fail SHALL be discarded.
REQ-030 When game_reset is sampled high, in any state:
- current_round SHALL be 1, difficulty_k K_INIT, total_score 0, lives MAX_LIVES, game_state PLAY.
- high_score SHALL be retained.
- game_reset SHALL have priority over both events.
REQ-031 score_evt SHALL be 0 in every cycle in which total_score does not change, including on game_reset.

Reset
REQ-032 When rst_n is sampled low, the reset values SHALL be:
- current_round=1, difficulty_k=K_INIT, total_score=0, high_score=0
- lives=MAX_LIVES, game_state=PLAY, score_evt=0
- both edge-detect registers=0
REQ-033 rst_n SHALL have priority over game_reset and over all events.
REQ-034 rst_n asserted mid-game SHALL leave no residual state, including high_score.

Structure
REQ-035 The game_state encoding and the default parameter constants SHALL live in shared package game_pkg.
REQ-036 Rising-edge detection SHALL be one sub-module, edge_detect, instantiated once per event input.
REQ-037 Points per round SHALL be computed from parameters only, with no lookup table.

Verification (all parameters at default)
REQ-038 Scenario: five clear pulses from reset -> scores 10, 25, 45, 70, 100; round 5; difficulty_k 8; game_state WON; high_score 100.
REQ-039 Scenario: round_clear held high for 10 cycles -> exactly one score_evt and total_score 10.
REQ-040 Scenario: three fail pulses in round 1 -> lives 2, 1, 0; game_state OVER; total_score 0; a further clear is ignored.
REQ-041 Scenario: clear and fail rising in the same cycle -> total_score 10 and lives 3.
REQ-042 Scenario: WON with score 100, then game_reset, then one clear -> high_score 100, total_score 10, round 2.
REQ-043 Scenario: SCORE_W=6, clear through round 5 -> total_score saturates at 63; rst_n low mid-game -> all outputs at their reset values.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game progress controller: state encoding and
// the default parameter constants used by the top level.
package game_pkg;

    typedef enum logic [1:0] {
        GS_PLAY = 2'd0,
        GS_OVER = 2'd1,
        GS_WON  = 2'd2
    } game_state_t;

    localparam int DEF_NUM_ROUNDS = 5;
    localparam int DEF_SCORE_W    = 16;
    localparam int DEF_K_W        = 4;
    localparam int DEF_K_INIT     = 4;
    localparam int DEF_BASE_PTS   = 10;
    localparam int DEF_STEP_PTS   = 5;
    localparam int DEF_MAX_LIVES  = 3;

    localparam int LIVES_W = 3;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: compares the live input against a registered copy,
// so the pulse appears in the cycle the input is first high.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic din_reg;

    // Registered copy of the input, cleared by reset so a level that is
    // already high when reset releases still counts as one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            din_reg <= 1'b0;
        end else begin
            din_reg <= din;
        end
    end

    assign pulse = din & ~din_reg;

endmodule

// File: rtl/game_progress_ctrl.sv
// Round/score/lives tracker for a simple quiz-style game. Events are edge
// detected, applied on the same edge they are first seen, and the best final
// score survives game restarts until rst_n.
module game_progress_ctrl
    import game_pkg::*;
#(
    parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
    parameter int SCORE_W    = DEF_SCORE_W,
    parameter int K_W        = DEF_K_W,
    parameter int K_INIT     = DEF_K_INIT,
    parameter int BASE_PTS   = DEF_BASE_PTS,
    parameter int STEP_PTS   = DEF_STEP_PTS,
    parameter int MAX_LIVES  = DEF_MAX_LIVES,
    localparam int ROUND_W   = $clog2(NUM_ROUNDS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               round_clear,
    input  logic               game_fail,
    input  logic               game_reset,
    output logic [ROUND_W-1:0] current_round,
    output logic [K_W-1:0]     difficulty_k,
    output logic [SCORE_W-1:0] total_score,
    output logic [SCORE_W-1:0] high_score,
    output logic [LIVES_W-1:0] lives,
    output logic [1:0]         game_state,
    output logic               score_evt
);

    // Wide enough that score + points can never wrap before saturation.
    localparam int ACC_W = SCORE_W + 33;
    localparam logic [ACC_W-1:0] SCORE_MAX = {{(ACC_W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

    logic clear_pulse;
    logic fail_pulse;

    edge_detect u_clear_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (round_clear),
        .pulse (clear_pulse)
    );

    edge_detect u_fail_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (game_fail),
        .pulse (fail_pulse)
    );

    game_state_t        state_reg, state_next;
    logic [ROUND_W-1:0] round_reg, round_next;
    logic [K_W-1:0]     k_reg, k_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [SCORE_W-1:0] high_reg, high_next;
    logic [LIVES_W-1:0] lives_reg, lives_next;
    logic               evt_reg, evt_next;

    logic [ACC_W-1:0]   pts_wide;
    logic [ACC_W-1:0]   sum_wide;
    logic [SCORE_W-1:0] score_sat;

    // Points for the current round, derived arithmetically from the round
    // number, then added to the score with saturation.
    always_comb begin
        pts_wide  = ACC_W'(BASE_PTS) + ACC_W'(round_reg - 1'b1) * ACC_W'(STEP_PTS);
        sum_wide  = ACC_W'(score_reg) + pts_wide;
        score_sat = (sum_wide > SCORE_MAX) ? {SCORE_W{1'b1}} : sum_wide[SCORE_W-1:0];
    end

    // State register and all progress counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= GS_PLAY;
            round_reg <= ROUND_W'(1);
            k_reg     <= K_W'(K_INIT);
            score_reg <= '0;
            high_reg  <= '0;
            lives_reg <= LIVES_W'(MAX_LIVES);
            evt_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            round_reg <= round_next;
            k_reg     <= k_next;
            score_reg <= score_next;
            high_reg  <= high_next;
            lives_reg <= lives_next;
            evt_reg   <= evt_next;
        end
    end

    // Next-state logic: game_reset first, then clear (which wins over a
    // simultaneous fail); terminal states ignore events entirely.
    always_comb begin
        state_next = state_reg;
        round_next = round_reg;
        k_next     = k_reg;
        score_next = score_reg;
        high_next  = high_reg;
        lives_next = lives_reg;
        evt_next   = 1'b0;

        if (game_reset) begin
            state_next = GS_PLAY;
            round_next = ROUND_W'(1);
            k_next     = K_W'(K_INIT);
            score_next = '0;
            lives_next = LIVES_W'(MAX_LIVES);
        end else if (state_reg == GS_PLAY) begin
            if (clear_pulse) begin
                score_next = score_sat;
                evt_next   = (score_sat != score_reg);
                if (round_reg < ROUND_W'(NUM_ROUNDS)) begin
                    round_next = round_reg + 1'b1;
                    k_next     = (k_reg == {K_W{1'b1}}) ? k_reg : k_reg + 1'b1;
                end else begin
                    state_next = GS_WON;
                    if (score_sat > high_reg) begin
                        high_next = score_sat;
                    end
                end
            end else if (fail_pulse) begin
                lives_next = lives_reg - 1'b1;
                if (lives_reg == LIVES_W'(1)) begin
                    state_next = GS_OVER;
                    if (score_reg > high_reg) begin
                        high_next = score_reg;
                    end
                end
            end
        end
    end

    assign current_round = round_reg;
    assign difficulty_k  = k_reg;
    assign total_score   = score_reg;
    assign high_score    = high_reg;
    assign lives         = lives_reg;
    assign game_state    = state_reg;
    assign score_evt     = evt_reg;

endmodule
